mdu_seq: RTL and testbench



---
 rtl/mdu_pkg.sv | 37 +++
 rtl/mdu_arith.sv | 70 +++++++
 rtl/mdu_seq.sv | 124 ++++++++++++
 tb/tb_mdu_seq.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared op codes, FSM state type and op classification helpers for the multiply/divide unit.
package mdu_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_long(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || is_div(op) ||
               (op == OP_MADD) || (op == OP_MADDU) ||
               (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

    function automatic int lat_sel(input logic [3:0] op, input int mult_lat, input int div_lat);
        return is_div(op) ? div_lat : mult_lat;
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational next-{hi,lo} for every long op; hi/lo pass through unchanged for anything else,
// including divide by zero.
module mdu_arith
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi_n,
    output logic [WIDTH-1:0] lo_n
);

    localparam int W2 = 2 * WIDTH;

    logic signed [W2-1:0]    a_sx;
    logic signed [W2-1:0]    b_sx;
    logic [W2-1:0]           prod_s;
    logic [W2-1:0]           prod_u;
    logic [W2-1:0]           acc;
    logic signed [WIDTH-1:0] quo_s;
    logic signed [WIDTH-1:0] rem_s;
    logic                    min_by_neg1;

    assign a_sx   = $signed({{WIDTH{a[WIDTH-1]}}, a});
    assign b_sx   = $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign prod_s = a_sx * b_sx;
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign acc    = {hi, lo};
    assign quo_s  = $signed(a) / $signed(b);
    assign rem_s  = $signed(a) % $signed(b);

    // The signed quotient would overflow here, so the result is pinned explicitly.
    assign min_by_neg1 = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == {WIDTH{1'b1}});

    always_comb begin
        hi_n = hi;
        lo_n = lo;
        case (op)
            OP_MULT:  {hi_n, lo_n} = prod_s;
            OP_MULTU: {hi_n, lo_n} = prod_u;
            OP_MADD:  {hi_n, lo_n} = acc + prod_s;
            OP_MADDU: {hi_n, lo_n} = acc + prod_u;
            OP_MSUB:  {hi_n, lo_n} = acc - prod_s;
            OP_MSUBU: {hi_n, lo_n} = acc - prod_u;
            OP_DIV: begin
                if (b != '0) begin
                    if (min_by_neg1) begin
                        lo_n = a;
                        hi_n = '0;
                    end else begin
                        lo_n = quo_s;
                        hi_n = rem_s;
                    end
                end
            end
            OP_DIVU: begin
                if (b != '0) begin
                    lo_n = a / b;
                    hi_n = a % b;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit: owns HI/LO, models op latency with a busy down-counter.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | no long op in flight; mthi/mtlo and long-op accepts allowed
//  RUN     | long op counting down; result held in pending regs
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int OP_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cancel,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             stall_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rdata
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT) + 1;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic [WIDTH-1:0] hi_n, lo_n;
    logic [3:0]       opc;
    logic             accept;

    assign opc    = 4'(op);
    assign busy   = (state_q == ST_RUN);
    assign accept = start & ~cancel & ~busy;
    assign stall_req = busy | (start & ~cancel & is_long(opc));
    assign hi = hi_q;
    assign lo = lo_q;

    mdu_arith #(.WIDTH(WIDTH)) u_arith (
        .op   (opc),
        .a    (a),
        .b    (b),
        .hi   (hi_q),
        .lo   (lo_q),
        .hi_n (hi_n),
        .lo_n (lo_n)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_long(opc)) begin
                        state_d   = ST_RUN;
                        cnt_d     = CW'(lat_sel(opc, MULT_LAT, DIV_LAT) - 1);
                        pend_hi_d = hi_n;
                        pend_lo_d = lo_n;
                    end else if (opc == OP_MTHI) begin
                        hi_d = a;
                    end else if (opc == OP_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            ST_RUN: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (opc == OP_MFHI)      rdata = hi_q;
        else if (opc == OP_MFLO) rdata = lo_q;
    end

    // The hazard unit is expected to stall rather than issue into a busy unit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(start && !cancel && busy))
                else $warning("mdu_seq: start ignored while busy");
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: latency, arithmetic, accumulate, cancel, ignored start and reset abort.
module tb_mdu_seq;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        cancel;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rdata;

    int passed = 0;
    int total  = 0;
    int bc;

    mdu_seq #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10), .OP_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cancel    (cancel),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo),
        .rdata     (rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op for a single cycle, then count busy cycles (bounded).
    task automatic run_op(input logic [3:0] o, input logic [31:0] va, input logic [31:0] vb,
                          output int cycles);
        start = 1'b1; op = o; a = va; b = vb;
        tick();
        start = 1'b0; op = OP_NONE;
        cycles = 0;
        while (busy && cycles < 40) begin
            cycles++;
            tick();
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; cancel = 1'b0; op = OP_NONE; a = '0; b = '0;
        tick(); tick();
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_stall", 32'(stall_req), 32'd0);

        // MULT -3 * 7 with explicit cycle-by-cycle busy window
        start = 1'b1; op = OP_MULT; a = 32'hFFFF_FFFD; b = 32'd7;
        #1;
        check("mult_stall_t", 32'(stall_req), 32'd1);
        check("mult_busy_t", 32'(busy), 32'd0);
        tick();
        start = 1'b0; op = OP_NONE;
        for (int i = 1; i <= 5; i++) begin
            check($sformatf("mult_busy_t%0d", i), 32'(busy), 32'd1);
            tick();
        end
        check("mult_busy_t6", 32'(busy), 32'd0);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFEB);

        run_op(OP_DIVU, 32'd100, 32'd7, bc);
        check("divu_lat", 32'(bc), 32'd10);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, bc);
        check("div_lat", 32'(bc), 32'd10);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        // mthi/mtlo are single-cycle, then accumulate on top
        run_op(OP_MTLO, 32'd0, 32'd0, bc);
        check("mtlo_busy", 32'(bc), 32'd0);
        check("mtlo_lo", lo, 32'd0);
        run_op(OP_MTHI, 32'd5, 32'd0, bc);
        check("mthi_busy", 32'(bc), 32'd0);
        check("mthi_hi", hi, 32'd5);
        run_op(OP_MADDU, 32'd2, 32'd3, bc);
        check("maddu_lat", 32'(bc), 32'd5);
        check("maddu_hi", hi, 32'd5);
        check("maddu_lo", lo, 32'd6);
        run_op(OP_MSUB, 32'd1, 32'd1, bc);
        check("msub_hi", hi, 32'd5);
        check("msub_lo", lo, 32'd5);

        // divide by zero keeps hi/lo but still takes the full latency
        run_op(OP_MTHI, 32'd11, 32'd0, bc);
        run_op(OP_MTLO, 32'd22, 32'd0, bc);
        run_op(OP_DIV, 32'd123, 32'd0, bc);
        check("div0_lat", 32'(bc), 32'd10);
        check("div0_hi", hi, 32'd11);
        check("div0_lo", lo, 32'd22);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, bc);
        check("divmin_lo", lo, 32'h8000_0000);
        check("divmin_hi", hi, 32'h0);

        // cancel masks start in the same cycle
        start = 1'b1; cancel = 1'b1; op = OP_MULT; a = 32'd9; b = 32'd9;
        #1;
        check("cancel_stall", 32'(stall_req), 32'd0);
        tick();
        start = 1'b0; cancel = 1'b0; op = OP_NONE;
        check("cancel_busy", 32'(busy), 32'd0);
        tick(); tick(); tick(); tick(); tick(); tick();
        check("cancel_hi", hi, 32'h0);
        check("cancel_lo", lo, 32'h8000_0000);

        // MULTU in flight: mfhi sees old hi, a start during RUN is dropped
        start = 1'b1; op = OP_MULTU; a = 32'hFFFF_FFFF; b = 32'd2;
        tick();
        start = 1'b0; op = OP_MFHI;
        #1;
        check("run_rdata_hi", rdata, 32'h0);
        tick();
        start = 1'b1; op = OP_MTLO; a = 32'd77;
        #1;
        check("run_stall", 32'(stall_req), 32'd1);
        tick();
        start = 1'b0; op = OP_NONE;
        check("ignored_mtlo", lo, 32'h8000_0000);
        bc = 0;
        while (busy && bc < 40) begin
            bc++;
            tick();
        end
        check("multu_rest_lat", 32'(bc), 32'd3);
        op = OP_MFHI;
        #1;
        check("multu_mfhi", rdata, 32'h1);
        op = OP_MFLO;
        #1;
        check("multu_mflo", rdata, 32'hFFFF_FFFE);
        op = OP_NONE;
        #1;
        check("none_rdata", rdata, 32'h0);

        // reset in cycle 3 of a DIVU discards it
        run_op(OP_MTHI, 32'h33, 32'd0, bc);
        start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
        tick();
        start = 1'b0; op = OP_NONE;
        tick(); tick();
        check("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        for (int i = 0; i < 12; i++) tick();
        check("late_busy", 32'(busy), 32'd0);
        check("late_hi", hi, 32'h0);
        check("late_lo", lo, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
